// File: rtl/lcd_write_engine_pkg.sv
// Shared LCD definitions: write-engine state encoding, command constants and
// default bus/exec timing at 50 MHz.
package lcd_write_engine_pkg;

  localparam int CNT_W = 17;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_PULSE = 3'd2,
    S_HOLD  = 3'd3,
    S_EXEC  = 3'd4,
    S_DONE  = 3'd5
  } lcd_state_e;

  localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_CMD_HOME  = 8'h02;

  localparam int unsigned DEF_T_SETUP     = 4;
  localparam int unsigned DEF_T_EN        = 16;
  localparam int unsigned DEF_T_HOLD      = 4;
  localparam int unsigned DEF_T_EXEC      = 2000;
  localparam int unsigned DEF_T_EXEC_LONG = 82000;

  // Clear (0x01) and home (0x02/0x03) need the long execution wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] d);
    return !rs && ((d[7:1] == 7'b0000000) || (d[7:2] == 6'b000000 && d[1]));
  endfunction

endpackage

// File: rtl/lcd_write_engine_if.sv
// Sequencer-side handshake plus LCD pin bundle for the write engine.
interface lcd_write_engine_if;
  logic [7:0] iDATA;
  logic       iRS;
  logic       iStart;
  logic       oDone;
  logic       oBusy;
  logic [7:0] LCD_DATA;
  logic       LCD_RW;
  logic       LCD_EN;
  logic       LCD_RS;

  modport master (output iDATA, iRS, iStart,
                  input  oDone, oBusy, LCD_DATA, LCD_RW, LCD_EN, LCD_RS);
  modport slave  (input  iDATA, iRS, iStart,
                  output oDone, oBusy, LCD_DATA, LCD_RW, LCD_EN, LCD_RS);
endinterface

// File: rtl/lcd_write_engine_timer.sv
// Shared phase timer: load N-1, count down, expired while the count is zero.
module lcd_delay_timer
  import lcd_write_engine_pkg::*;
(
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N)          cnt <= '0;
    else if (load)        cnt <= load_val;
    else if (cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign expired = (cnt == '0);
endmodule

// File: rtl/lcd_write_engine.sv
// HD44780 write cycle generator: setup, enable pulse, hold, execution wait,
// then a one-cycle done pulse. All pin outputs come straight from flops.
module lcd_write_engine
  import lcd_write_engine_pkg::*;
#(
  parameter int unsigned T_SETUP     = DEF_T_SETUP,
  parameter int unsigned T_EN        = DEF_T_EN,
  parameter int unsigned T_HOLD      = DEF_T_HOLD,
  parameter int unsigned T_EXEC      = DEF_T_EXEC,
  parameter int unsigned T_EXEC_LONG = DEF_T_EXEC_LONG
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  lcd_write_engine_if.slave  bus
);
  localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] LD_EN    = CNT_W'(T_EN - 1);
  localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] LD_EXEC  = CNT_W'(T_EXEC - 1);
  localparam logic [CNT_W-1:0] LD_LONG  = CNT_W'(T_EXEC_LONG - 1);

  lcd_state_e       state, state_nxt;
  logic             start_d, accept, is_long;
  logic             ld, expired;
  logic [CNT_W-1:0] ld_val;
  logic             en, done, busy, rs;
  logic [7:0]       data;
  logic             en_nxt, done_nxt, busy_nxt;

  assign accept = (state == S_IDLE) && bus.iStart && !start_d;

  lcd_delay_timer u_timer (
    .iCLK     (iCLK),
    .iRST_N   (iRST_N),
    .load     (ld),
    .load_val (ld_val),
    .expired  (expired)
  );

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ld        = 1'b0;
    ld_val    = '0;
    unique case (state)
      S_IDLE:  if (accept)  begin state_nxt = S_SETUP; ld = 1'b1; ld_val = LD_SETUP; end
      S_SETUP: if (expired) begin state_nxt = S_PULSE; ld = 1'b1; ld_val = LD_EN;    end
      S_PULSE: if (expired) begin state_nxt = S_HOLD;  ld = 1'b1; ld_val = LD_HOLD;  end
      S_HOLD:  if (expired) begin
        state_nxt = S_EXEC;
        ld        = 1'b1;
        ld_val    = is_long ? LD_LONG : LD_EXEC;
      end
      S_EXEC:  if (expired) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so each pin
  // changes on the same edge as the state it belongs to.
  always_comb begin
    en_nxt   = (state_nxt == S_PULSE);
    done_nxt = (state_nxt == S_DONE);
    busy_nxt = (state_nxt != S_IDLE);
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      start_d <= 1'b0;
      en      <= 1'b0;
      done    <= 1'b0;
      busy    <= 1'b0;
      data    <= 8'h00;
      rs      <= 1'b0;
      is_long <= 1'b0;
    end else begin
      start_d <= bus.iStart;
      en      <= en_nxt;
      done    <= done_nxt;
      busy    <= busy_nxt;
      if (accept) begin
        data    <= bus.iDATA;
        rs      <= bus.iRS;
        is_long <= is_long_cmd(bus.iRS, bus.iDATA);
      end
    end
  end

  assign bus.LCD_EN   = en;
  assign bus.LCD_RW   = 1'b0;
  assign bus.LCD_RS   = rs;
  assign bus.LCD_DATA = data;
  assign bus.oDone    = done;
  assign bus.oBusy    = busy;
endmodule

// File: tb/tb_lcd_write_engine.sv
// Randomized bench for lcd_write_engine against a timeline model of each write.
module tb_lcd_write_engine;
  import lcd_write_engine_pkg::*;

  localparam int TS = 2, TE = 3, TH = 2, TX = 5, TXL = 20;

  logic iCLK = 1'b0;
  logic iRST_N = 1'b0;

  lcd_write_engine_if bus();

  lcd_write_engine #(
    .T_SETUP(TS), .T_EN(TE), .T_HOLD(TH), .T_EXEC(TX), .T_EXEC_LONG(TXL)
  ) dut (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .bus    (bus)
  );

  always #5 iCLK = ~iCLK;

  int n_vec = 0, n_err = 0;
  int cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference: a write is a timeline starting at its acceptance cycle.
  function automatic int exp_total(input logic rs, input logic [7:0] d);
    bit lng;
    lng = !rs && (d == 8'h00 || d == 8'h01 || d == 8'h02 || d == 8'h03);
    return TS + TE + TH + (lng ? TXL : TX);
  endfunction

  int         m_acc = -1, m_tot = 0;
  logic [7:0] m_data = 8'h00;
  logic       m_rs = 1'b0, m_prev = 1'b0;

  initial forever begin
    @(posedge iCLK or negedge iRST_N);
    if (!iRST_N) begin
      m_acc = -1; m_data = 8'h00; m_rs = 1'b0; m_prev = 1'b0;
    end else begin
      cyc++;
      if ((m_acc < 0 || cyc - 1 > m_acc + m_tot) && bus.iStart && !m_prev) begin
        m_acc  = cyc;
        m_data = bus.iDATA;
        m_rs   = bus.iRS;
        m_tot  = exp_total(bus.iRS, bus.iDATA);
      end
      m_prev = bus.iStart;
    end
  end

  function automatic logic [12:0] exp_pins();
    int k;
    logic act, b, d, e;
    k   = cyc - m_acc;
    act = (m_acc >= 0);
    b   = act && k <= m_tot;
    d   = act && k == m_tot;
    e   = act && k >= TS && k < TS + TE;
    return {b, d, e, 1'b0, m_rs, m_data};
  endfunction

  function automatic logic [12:0] pins();
    return {bus.oBusy, bus.oDone, bus.LCD_EN, bus.LCD_RW, bus.LCD_RS, bus.LCD_DATA};
  endfunction

  // Pin monitor: per-cycle model compare plus event capture for scenarios.
  int   en_rises = 0, done_cnt = 0, done_cyc = 0, busy_rise = 0, en_first = 0, en_len = 0;
  logic en_q = 1'b0, busy_q = 1'b0;
  logic [8:0] capq[$];

  initial forever begin
    @(negedge iCLK);
    chk("pins", 32'(pins()), 32'(exp_pins()));
    if (bus.LCD_EN && !en_q) begin
      en_rises++; en_first = cyc; en_len = 0;
      capq.push_back({bus.LCD_RS, bus.LCD_DATA});
    end
    if (bus.LCD_EN) en_len++;
    if (bus.oDone) begin done_cnt++; done_cyc = cyc; end
    if (bus.oBusy && !busy_q) busy_rise = cyc;
    en_q   = bus.LCD_EN;
    busy_q = bus.oBusy;
  end

  task automatic step();
    @(negedge iCLK); #2;
  endtask

  task automatic wait_done(input int c0);
    int ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (done_cnt != c0) begin ok = 1; break; end
    end
    chk("done_timeout", 32'(ok), 32'd1);
  endtask

  // Sequencer-style write: hold iStart until done, drop it in the done cycle.
  task automatic do_write(input logic [7:0] d, input logic rs, input string tag, output int lat);
    int t0, c0, e0;
    c0 = done_cnt; e0 = en_rises;
    bus.iDATA = d; bus.iRS = rs; bus.iStart = 1'b1;
    t0 = cyc + 1;
    wait_done(c0);
    bus.iStart = 1'b0;
    lat = done_cyc - t0;
    chk({tag, "_lat"},    32'(lat),           32'(exp_total(rs, d)));
    chk({tag, "_en_ofs"}, 32'(en_first - t0), 32'(TS));
    chk({tag, "_en_len"}, 32'(en_len),        32'(TE));
    chk({tag, "_en_cnt"}, 32'(en_rises - e0), 32'd1);
    step();
  endtask

  initial begin
    int lat, t0, c0, e0, d1;
    int lats[5];
    logic [8:0] seq[5];
    seq = '{9'h038, 9'h00C, 9'h001, 9'h006, 9'h080};
    bus.iDATA = 8'h00; bus.iRS = 1'b0; bus.iStart = 1'b0;

    repeat (2) @(negedge iCLK);
    chk("reset_pins", 32'(pins()), 32'd0);
    #2 iRST_N = 1'b1;
    step();

    do_write(8'h41, 1'b1, "data41", lat);
    do_write(8'h01, 1'b0, "clear", lat);
    do_write(8'h03, 1'b0, "home3", lat);
    do_write(8'h06, 1'b0, "entry", lat);

    // Retrigger pulses at cycles 5 and 10 must be ignored.
    c0 = done_cnt; e0 = en_rises;
    bus.iDATA = 8'h55; bus.iRS = 1'b1; bus.iStart = 1'b1;
    t0 = cyc + 1;
    step();
    bus.iStart = 1'b0; bus.iDATA = 8'hAA; bus.iRS = 1'b0;
    while (cyc < t0 + 4) step();
    bus.iStart = 1'b1; step(); bus.iStart = 1'b0;
    while (cyc < t0 + 9) step();
    bus.iStart = 1'b1; step(); bus.iStart = 1'b0;
    wait_done(c0);
    chk("retrig_lat", 32'(done_cyc - t0), 32'd12);
    repeat (10) step();
    chk("retrig_done_cnt", 32'(done_cnt - c0), 32'd1);
    chk("retrig_en_cnt",   32'(en_rises - e0), 32'd1);
    chk("retrig_data",     32'(bus.LCD_DATA),  32'h55);

    // Handshake: second write accepted two cycles after the first done.
    do_write(8'h28, 1'b0, "hs1", lat);
    d1 = done_cyc;
    do_write(8'h0C, 1'b0, "hs2", lat);
    chk("hs_gap", 32'(busy_rise - d1), 32'd2);

    // iStart held high past done must not start another write.
    c0 = done_cnt; e0 = en_rises;
    bus.iDATA = 8'h38; bus.iRS = 1'b0; bus.iStart = 1'b1;
    wait_done(c0);
    repeat (30) step();
    chk("held_done_cnt", 32'(done_cnt - c0), 32'd1);
    chk("held_en_cnt",   32'(en_rises - e0), 32'd1);
    bus.iStart = 1'b0;
    step();

    // Reset during the enable pulse clears outputs without a clock edge.
    bus.iDATA = 8'h77; bus.iRS = 1'b1; bus.iStart = 1'b1;
    step();
    bus.iStart = 1'b0;
    for (int i = 0; i < 20 && !bus.LCD_EN; i++) step();
    chk("rst_in_pulse", 32'(bus.LCD_EN), 32'd1);
    iRST_N = 1'b0;
    #1 chk("rst_async", 32'(pins()), 32'd0);
    step(); step();
    iRST_N = 1'b1;
    step();
    do_write(8'h80, 1'b0, "post_rst", lat);

    // Init sequence from a model sequencer.
    capq.delete();
    foreach (seq[i]) do_write(seq[i][7:0], seq[i][8], "init", lats[i]);
    chk("init_cap_n", 32'(capq.size()), 32'd5);
    foreach (seq[i]) if (i < capq.size()) chk("init_cap", 32'(capq[i]), 32'(seq[i]));
    chk("init_clear_extra", 32'(lats[2] - lats[0]), 32'd15);

    // Random iStart/data traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 600; i++) begin
      bus.iStart = ($urandom_range(0, 2) == 0);
      bus.iRS    = 1'($urandom_range(0, 1));
      bus.iDATA  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      step();
    end
    bus.iStart = 1'b0;
    repeat (40) step();

    for (int i = 0; i < 10; i++) begin
      logic [7:0] d;
      logic       r;
      d = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      r = 1'($urandom_range(0, 1));
      do_write(d, r, "rand", lat);
      repeat ($urandom_range(0, 3)) step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
